instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 1024, meaning the number of 32-bit words in instruction memory.
REQ-002 The block SHALL have parameter ADDR_W, default $clog2(IMEM_DEPTH), meaning the word-address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning a pulse that begins a load session.
REQ-006 The block SHALL have port byte_valid, input, 1, meaning byte_data holds a valid byte.
REQ-007 The block SHALL have port byte_data, input, 8, meaning the incoming serial-loader byte.
REQ-008 The block SHALL have port byte_ready, output, 1, meaning the block accepts a byte this cycle.
REQ-009 The block SHALL have port imem_we, output, 1, meaning the instruction-memory write strobe.
REQ-010 The block SHALL have port imem_addr, output, ADDR_W, meaning the instruction-memory word address.
REQ-011 The block SHALL have port imem_wdata, output, 32 (common_pkg::instruction_t), meaning the assembled instruction word.
REQ-012 The block SHALL have port cpu_hold, output, 1, meaning the core is held while loading.
REQ-013 The block SHALL have port done, output, 1, meaning the last load completed successfully.
REQ-014 The block SHALL have port error, output, 1, meaning the last load was rejected.

Function
REQ-015 A byte SHALL be transferred only on a rising edge where byte_valid and byte_ready are both 1.
REQ-016 The FSM SHALL have states IDLE, LEN, DATA, DONE and ERR.
REQ-017 byte_ready SHALL be 1 exactly in LEN and DATA, combinationally from state only.
REQ-018 start in IDLE, DONE or ERR SHALL move to LEN and clear done, error, the byte counter and the word counter; start in LEN or DATA SHALL be ignored.
REQ-019 In LEN, four transferred bytes SHALL form a 32-bit word count N, little-endian (first byte = bits 7:0).
REQ-020 On the 4th LEN byte: N=0 -> DONE; N>IMEM_DEPTH -> ERR; otherwise -> DATA.
REQ-021 In DATA, each group of four transferred bytes SHALL form one instruction, little-endian (first byte = opcode field bits 7:0).
REQ-022 On the cycle after the 4th byte of word k (k from 0), imem_we SHALL be 1 for exactly one cycle with imem_addr=k and imem_wdata=the word.
REQ-023 byte_ready SHALL remain 1 during the write cycle, so back-to-back bytes at one byte/cycle are accepted without stall.
REQ-024 After the write of word N-1 is issued, the FSM SHALL enter DONE on that same edge, with no further byte accepted for this session.
REQ-025 imem_addr and imem_wdata SHALL hold their last written values when imem_we is 0.
REQ-026 cpu_hold SHALL be 1 in LEN and DATA, and also during the final write cycle; otherwise 0.
REQ-027 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR; both SHALL stay until start or rst.
REQ-028 The word counter SHALL be ADDR_W+1 bits wide so that N=IMEM_DEPTH completes without wrap, writing addresses 0..IMEM_DEPTH-1.
REQ-029 Bytes presented while byte_ready=0 SHALL be ignored with no state change.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, error=0, and clear all counters.
REQ-031 rst asserted mid-load SHALL abort the session immediately; words already written SHALL NOT be rolled back, and no partial word SHALL be written.
REQ-032 Release of rst SHALL leave the block in IDLE, waiting for start.

Verification
REQ-033 Length scenario: start, then bytes 02 00 00 00 13 00 00 00 93 00 10 00 at 1/cycle -> imem_we pulses with addr 0 data 0x00000013, then addr 1 data 0x00100093; done=1, cpu_hold=0.
REQ-034 Zero-length scenario: start, then bytes 00 00 00 00 -> DONE, no imem_we, done=1.
REQ-035 Oversize scenario: IMEM_DEPTH=4; start, then length 05 00 00 00 -> error=1, byte_ready=0, no imem_we; a second start -> LEN with error=0.
REQ-036 Throttled-source scenario: random byte_valid gaps and bytes offered in IDLE/DONE -> identical memory image, and ignored bytes cause no writes.
REQ-037 Full-depth scenario: N=IMEM_DEPTH -> last write at addr IMEM_DEPTH-1 and done=1, with no write to addr 0 after wrap.
REQ-038 Mid-load reset scenario: rst after 2 of 4 bytes of word 1 -> all outputs at reset values, word 0 kept in memory, no write to addr 1.

Source files
------------

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Receives a program over a byte stream and writes it into instruction
//   memory while holding the core.
//
//   A session is started by a pulse on start. The first four accepted bytes
//   are the word count N, little-endian. They are followed by N instructions
//   of four bytes each, also little-endian. Each instruction is written to
//   word address k (0..N-1) one cycle after its last byte is accepted.
//
//   Ports
//     clk, rst               clock; asynchronous active-high reset
//     start                  pulse: begin a new load session
//     byte_valid, byte_data  incoming byte stream
//     byte_ready             byte is accepted when byte_valid & byte_ready
//     imem_we, imem_addr,    one-cycle write strobe with address and data;
//     imem_wdata             address and data hold between writes
//     cpu_hold               core held while a session is active
//     done, error            result of the last session, sticky until start
// -----------------------------------------------------------------------------
module instr_loader #(
   parameter int IMEM_DEPTH = 1024,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

   state_t          state;
   logic [1:0]      byte_cnt;
   logic [23:0]     shift_q;     // first three bytes of the current group
   logic [ADDR_W:0] word_cnt;    // one extra bit so N = IMEM_DEPTH cannot wrap
   logic [ADDR_W:0] len_q;
   logic [ADDR_W:0] word_cnt_nxt;
   logic            xfer;
   logic            group_end;
   logic [31:0]     word_now;

   assign byte_ready   = (state == LEN) || (state == DATA);
   assign xfer         = byte_valid && byte_ready;
   assign group_end    = xfer && (byte_cnt == 2'd3);
   // The byte on the bus completes the group: it becomes bits 31:24.
   assign word_now     = {byte_data, shift_q};
   assign word_cnt_nxt = word_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         byte_cnt   <= 2'd0;
         shift_q    <= 24'd0;
         word_cnt   <= '0;
         len_q      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         cpu_hold   <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         imem_we <= 1'b0;

         // Bytes shift in at the top, so the first byte ends up in bits 7:0.
         if (xfer) begin
            shift_q  <= {byte_data, shift_q[23:8]};
            byte_cnt <= byte_cnt + 1'b1;
         end

         case (state)
            IDLE, DONE, ERR: begin
               // Also drops cpu_hold one cycle after the final write.
               cpu_hold <= start;
               if (start) begin
                  state    <= LEN;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  byte_cnt <= 2'd0;
                  word_cnt <= '0;
               end
            end

            LEN: begin
               if (group_end) begin
                  if (word_now == 32'd0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else if (word_now > DEPTH_W) begin
                     state    <= ERR;
                     error    <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= DATA;
                     len_q <= word_now[ADDR_W:0];
                  end
               end
            end

            DATA: begin
               if (group_end) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_cnt[ADDR_W-1:0];
                  imem_wdata <= word_now;
                  word_cnt   <= word_cnt_nxt;
                  // Last word: leave DATA now so no further byte is taken;
                  // cpu_hold stays high through the write cycle.
                  if (word_cnt_nxt == len_q) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               cpu_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Randomised scoreboard bench for instr_loader with IMEM_DEPTH = 4.
//   The reference model parses each session's byte list directly: the length
//   is the little-endian value of the first four bytes, and instruction k is
//   the little-endian value of bytes 4+4k..7+4k. Expected writes are queued
//   before the bytes are driven. A monitor pops one entry per imem_we pulse
//   and checks that address and data hold between writes.
// -----------------------------------------------------------------------------
module tb_instr_loader;

   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic          clk        = 1'b0;
   logic          rst        = 1'b0;
   logic          start      = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data  = 8'd0;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;

   instr_loader #(.IMEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] tx_q[$];
   int         checks   = 0;
   int         failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Monitor: pops one expected write per strobe, checks hold otherwise.
   initial begin
      logic [AW-1:0] last_addr;
      logic [31:0]   last_data;
      wr_t           e;
      last_addr = '0;
      last_data = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_addr = '0;
            last_data = 32'd0;
         end else if (imem_we === 1'b1) begin
            check("hold_during_write", 32'(cpu_hold), 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual addr=%0d data=0x%08h required no write",
                        imem_addr, imem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(imem_addr), 32'(e.addr));
               check("write_data", imem_wdata, e.data);
            end
            last_addr = imem_addr;
            last_data = imem_wdata;
         end else begin
            check("addr_hold", 32'(imem_addr), 32'(last_addr));
            check("data_hold", imem_wdata, last_data);
         end
      end
   end

   // Reference model: interprets tx_q by the loader rules, queues writes,
   // returns 0 for a completed session and 1 for a rejected one.
   function automatic int model_session();
      logic [31:0] n;
      wr_t         e;
      n = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
      if (n == 32'd0) return 0;
      if (n > 32'(DEPTH)) return 1;
      for (int k = 0; k < int'(n); k++) begin
         e.addr = AW'(k);
         e.data = {tx_q[4*k+7], tx_q[4*k+6], tx_q[4*k+5], tx_q[4*k+4]};
         exp_q.push_back(e);
      end
      return 0;
   endfunction

   task automatic build(input logic [31:0] n);
      tx_q.delete();
      for (int i = 0; i < 4; i++) tx_q.push_back(n[8*i +: 8]);
      if (n != 32'd0 && n <= 32'(DEPTH))
         for (int i = 0; i < 4 * int'(n); i++) tx_q.push_back(8'($urandom));
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("start_ready",  32'(byte_ready), 32'd1);
      check("start_hold",   32'(cpu_hold),   32'd1);
      check("start_done",   32'(done),       32'd0);
      check("start_error",  32'(error),      32'd0);
   endtask

   // Drives tx_q; a byte leaves the queue only when it was transferred.
   task automatic send_bytes(input int gap_pct, input bit poke_start);
      int budget;
      budget = 2000;
      while (tx_q.size() > 0) begin
         bit v;
         bit rdy;
         @(negedge clk);
         v          = ($urandom_range(99) >= gap_pct);
         byte_valid = v;
         byte_data  = v ? tx_q[0] : 8'($urandom);
         start      = poke_start && ($urandom_range(7) == 0);
         rdy        = byte_ready;
         @(posedge clk);
         if (v && rdy) void'(tx_q.pop_front());
         budget--;
         if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual left=%0d required 0", tx_q.size());
            tx_q.delete();
         end
      end
      #1;
      byte_valid = 1'b0;
      start      = 1'b0;
   endtask

   task automatic offer_junk(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_data  = 8'($urandom);
         check("junk_not_ready", 32'(byte_ready), 32'd0);
         @(posedge clk);
      end
      #1 byte_valid = 1'b0;
   endtask

   task automatic run_session(input int gap_pct, input bit poke);
      int st;
      st = model_session();
      do_start();
      send_bytes(gap_pct, poke);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("end_done",      32'(done),         (st == 0) ? 32'd1 : 32'd0);
      check("end_error",     32'(error),        (st == 1) ? 32'd1 : 32'd0);
      check("end_hold",      32'(cpu_hold),     32'd0);
      check("end_ready",     32'(byte_ready),   32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", 32'(byte_ready), 32'd0);
      check("rst_we",    32'(imem_we),    32'd0);
      check("rst_addr",  32'(imem_addr),  32'd0);
      check("rst_wdata", imem_wdata,      32'd0);
      check("rst_hold",  32'(cpu_hold),   32'd0);
      check("rst_done",  32'(done),       32'd0);
      check("rst_error", 32'(error),      32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Asynchronous reset, observed before any clock edge.
      #1 rst = 1'b1;
      #2 check_reset_outputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      offer_junk(3);

      // Two-word program at one byte per cycle.
      tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00};
      run_session(0, 1'b0);
      offer_junk(2);

      // Zero length.
      build(32'd0);
      run_session(0, 1'b0);

      // Oversize lengths, including one with only high bytes set.
      build(32'd5);
      run_session(0, 1'b0);
      offer_junk(2);
      build(32'h0001_0002);
      run_session(20, 1'b0);

      // Full depth, back to back.
      build(32'(DEPTH));
      run_session(0, 1'b0);

      // Random sessions with gaps, ignored start pulses and junk in DONE/ERR.
      for (int s = 0; s < 10; s++) begin
         build(32'($urandom_range(DEPTH + 1)));
         run_session(40, 1'b1);
         offer_junk(3);
      end

      // Reset after two bytes of word 1: word 0 stays written, word 1 never.
      build(32'd2);
      void'(model_session());
      void'(exp_q.pop_back());
      void'(tx_q.pop_back());
      void'(tx_q.pop_back());
      do_start();
      send_bytes(0, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      check("midload_queue", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      offer_junk(4);
      check("post_rst_done", 32'(done), 32'd0);

      // Fresh session after the aborted one.
      build(32'd3);
      run_session(25, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
